// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access widths, data-bus modes and
// the controller's state codes.
package lsu_pkg;

  localparam logic [1:0] W_BYTE = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_WORD = 2'b10;
  localparam logic [1:0] W_ILL  = 2'b11;

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_READ  = 2'b01;
  localparam logic [1:0] MODE_WRITE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } lsu_state_e;

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ISSUE = ST_ISSUE;
  localparam logic [1:0] S_RESP  = ST_RESP;

endpackage

// File: rtl/lsu_access_check.sv
// Combinational legality check of one access: width code, natural alignment,
// and whether every touched byte lies inside the data SRAM window.
module lsu_access_check
  import lsu_pkg::*;
#(
  parameter logic [31:0] SRAM_BASE_ADDR = 32'h3000,
  parameter logic [31:0] SRAM_SIZE      = 32'h1000
) (
  input  logic [31:0] addr,
  input  logic [1:0]  width,
  output logic        err,
  output logic [2:0]  bytes
);

  logic        misaligned;
  logic [32:0] end_addr;
  logic [32:0] limit;

  always_comb begin
    case (width)
      W_BYTE:  bytes = 3'd1;
      W_HALF:  bytes = 3'd2;
      default: bytes = 3'd4;
    endcase
  end

  assign misaligned = ((width == W_HALF) && addr[0]) ||
                      ((width == W_WORD) && (addr[1:0] != 2'b00));

  // 33-bit arithmetic so an access near 0xFFFFFFFF cannot wrap into range.
  assign end_addr = {1'b0, addr} + {30'd0, bytes};
  assign limit    = {1'b0, SRAM_BASE_ADDR} + {1'b0, SRAM_SIZE};

  assign err = (width == W_ILL) || misaligned ||
               (addr < SRAM_BASE_ADDR) || (end_addr > limit);

endmodule

// File: rtl/load_store_unit.sv
// Data-bus master: accepts one load/store, issues it for one cycle, then holds
// the response (and the memory's read result via stall_lw) until consumed.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [31:0] SRAM_BASE_ADDR = 32'h3000,
  parameter logic [31:0] SRAM_SIZE      = 32'h1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_width,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall_lw,
  output logic [31:0] data_bus_write,
  output logic [31:0] data_bus_addr,
  output logic [1:0]  data_bus_mode,
  output logic [1:0]  data_bus_reqw,
  output logic        data_bus_reqs,
  output logic        data_bus_select,
  input  logic [31:0] data_bus_read
);

  logic [1:0]  state_reg, state_next;
  logic        store_reg;
  logic [1:0]  width_reg;
  logic        signed_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        err_reg;

  logic        chk_err;
  logic [2:0]  chk_bytes;
  logic        unused_bytes;

  lsu_access_check #(
    .SRAM_BASE_ADDR(SRAM_BASE_ADDR),
    .SRAM_SIZE     (SRAM_SIZE)
  ) u_check (
    .addr (req_addr),
    .width(req_width),
    .err  (chk_err),
    .bytes(chk_bytes)
  );

  assign unused_bytes = ^chk_bytes;

  logic accept;
  assign accept = (state_reg == S_IDLE) && req_valid;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (req_valid) state_next = chk_err ? S_RESP : S_ISSUE;
      S_ISSUE: state_next = S_RESP;
      S_RESP:  if (rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      store_reg  <= 1'b0;
      width_reg  <= W_BYTE;
      signed_reg <= 1'b0;
      addr_reg   <= 32'd0;
      wdata_reg  <= 32'd0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        store_reg  <= req_store;
        width_reg  <= req_width;
        signed_reg <= req_signed;
        addr_reg   <= req_addr;
        wdata_reg  <= req_wdata;
        err_reg    <= chk_err;
      end
    end
  end

  logic is_issue;
  logic is_resp;
  logic resp_load;
  logic bus_active;

  assign is_issue   = (state_reg == S_ISSUE);
  assign is_resp    = (state_reg == S_RESP);
  assign resp_load  = is_resp && !store_reg && !err_reg;
  // A load keeps the bus in read mode through RESP so the memory output stays put.
  assign bus_active = is_issue || resp_load;

  assign req_ready = (state_reg == S_IDLE);
  assign rsp_valid = is_resp;
  assign rsp_err   = is_resp && err_reg;
  assign rsp_rdata = resp_load ? data_bus_read : 32'd0;
  assign stall_lw  = resp_load && !rsp_ready;

  assign data_bus_select = bus_active;
  assign data_bus_mode   = !bus_active ? MODE_IDLE :
                           (is_issue && store_reg) ? MODE_WRITE : MODE_READ;
  assign data_bus_reqw   = bus_active ? width_reg  : W_BYTE;
  assign data_bus_reqs   = bus_active && signed_reg;
  assign data_bus_addr   = bus_active ? addr_reg   : 32'd0;
  assign data_bus_write  = (is_issue && store_reg) ? wdata_reg : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a little-endian SRAM model that
// registers reads and honours stall_lw.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [1:0]  req_width = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall_lw;
  logic [31:0] data_bus_write;
  logic [31:0] data_bus_addr;
  logic [1:0]  data_bus_mode;
  logic [1:0]  data_bus_reqw;
  logic        data_bus_reqs;
  logic        data_bus_select;
  logic [31:0] data_bus_read;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_width(req_width), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .stall_lw(stall_lw),
    .data_bus_write(data_bus_write), .data_bus_addr(data_bus_addr),
    .data_bus_mode(data_bus_mode), .data_bus_reqw(data_bus_reqw),
    .data_bus_reqs(data_bus_reqs), .data_bus_select(data_bus_select),
    .data_bus_read(data_bus_read)
  );

  // SRAM model (no reset), read data registered one cycle after a read issue.
  logic [7:0]  mem [0:4095];
  logic [31:0] mem_rdata = 32'd0;
  logic [11:0] off;
  logic [31:0] raw;
  logic [31:0] ext;

  assign off = data_bus_addr[11:0] - 12'h000;
  assign raw = {mem[off + 12'd3], mem[off + 12'd2], mem[off + 12'd1], mem[off]};
  always_comb begin
    ext = raw;
    case (data_bus_reqw)
      2'b00: ext = data_bus_reqs ? {{24{raw[7]}}, raw[7:0]} : {24'd0, raw[7:0]};
      2'b01: ext = data_bus_reqs ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
      default: ext = raw;
    endcase
  end
  assign data_bus_read = mem_rdata;

  always @(posedge clk) begin
    if (data_bus_select && data_bus_mode == 2'b10) begin
      mem[off] <= data_bus_write[7:0];
      if (data_bus_reqw != 2'b00) mem[off + 12'd1] <= data_bus_write[15:8];
      if (data_bus_reqw == 2'b10) begin
        mem[off + 12'd2] <= data_bus_write[23:16];
        mem[off + 12'd3] <= data_bus_write[31:24];
      end
    end
    if (data_bus_select && data_bus_mode == 2'b01 && !stall_lw)
      mem_rdata <= ext;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one request at a falling edge and checks every phase; returns at the
  // falling edge where the unit is back in IDLE.
  task automatic do_op(input string tag, input logic st, input logic [1:0] w,
                       input logic sg, input logic [31:0] a, input logic [31:0] wd,
                       input logic exp_err, input logic [31:0] exp_rd);
    check({tag, " ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_store = st; req_width = w; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    if (exp_err) begin
      check({tag, " err_valid"}, {30'd0, rsp_valid, rsp_err}, 32'd3);
      check({tag, " err_bus"}, {29'd0, data_bus_select, data_bus_mode}, 32'd0);
      check({tag, " err_rdata"}, rsp_rdata, 32'd0);
    end else begin
      check({tag, " issue_sel_mode"}, {29'd0, data_bus_select, data_bus_mode},
            {29'd0, 1'b1, st ? 2'b10 : 2'b01});
      check({tag, " issue_addr"}, data_bus_addr, a);
      check({tag, " issue_wr"}, data_bus_write, st ? wd : 32'd0);
      check({tag, " issue_rspv"}, {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      check({tag, " rsp"}, {30'd0, rsp_valid, rsp_err}, 32'd2);
      check({tag, " rdata"}, rsp_rdata, exp_rd);
    end
    @(negedge clk);
    $display("op %s: store=%0d width=%0d signed=%0d addr=0x%08h rdata=0x%08h err=%0d",
             tag, st, w, sg, a, exp_rd, exp_err);
  endtask

  typedef struct {
    string       tag;
    logic        st;
    logic [1:0]  w;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[19];

  initial begin
    vecs[0]  = '{"st_w_3004",   1, 2'b10, 0, 32'h3004, 32'hDEADBEEF, 0, 32'h0};
    vecs[1]  = '{"ld_w_3004",   0, 2'b10, 0, 32'h3004, 32'h0, 0, 32'hDEADBEEF};
    vecs[2]  = '{"ld_hs_3004",  0, 2'b01, 1, 32'h3004, 32'h0, 0, 32'hFFFFBEEF};
    vecs[3]  = '{"ld_hu_3006",  0, 2'b01, 0, 32'h3006, 32'h0, 0, 32'h0000DEAD};
    vecs[4]  = '{"st_b_3801",   1, 2'b00, 0, 32'h3801, 32'h00000080, 0, 32'h0};
    vecs[5]  = '{"ld_bs_3801",  0, 2'b00, 1, 32'h3801, 32'h0, 0, 32'hFFFFFF80};
    vecs[6]  = '{"ld_bu_3801",  0, 2'b00, 0, 32'h3801, 32'h0, 0, 32'h00000080};
    vecs[7]  = '{"ld_h_3003",   0, 2'b01, 0, 32'h3003, 32'h0, 1, 32'h0};
    vecs[8]  = '{"ld_w_3002",   0, 2'b10, 0, 32'h3002, 32'h0, 1, 32'h0};
    vecs[9]  = '{"ld_ill_3000", 0, 2'b11, 0, 32'h3000, 32'h0, 1, 32'h0};
    vecs[10] = '{"ld_w_2ffc",   0, 2'b10, 0, 32'h2FFC, 32'h0, 1, 32'h0};
    vecs[11] = '{"st_w_3ffc",   1, 2'b10, 0, 32'h3FFC, 32'hCAFEF00D, 0, 32'h0};
    vecs[12] = '{"ld_w_3ffc",   0, 2'b10, 0, 32'h3FFC, 32'h0, 0, 32'hCAFEF00D};
    vecs[13] = '{"ld_w_3ffd",   0, 2'b10, 0, 32'h3FFD, 32'h0, 1, 32'h0};
    vecs[14] = '{"ld_w_4000",   0, 2'b10, 0, 32'h4000, 32'h0, 1, 32'h0};
    vecs[15] = '{"st_b_3fff",   1, 2'b00, 0, 32'h3FFF, 32'h000000A5, 0, 32'h0};
    vecs[16] = '{"ld_bu_3fff",  0, 2'b00, 0, 32'h3FFF, 32'h0, 0, 32'h000000A5};
    vecs[17] = '{"ld_bs_3fff",  0, 2'b00, 1, 32'h3FFF, 32'h0, 0, 32'hFFFFFFA5};
    vecs[18] = '{"st_h_fffe",   1, 2'b01, 0, 32'hFFFFFFFE, 32'h1234, 1, 32'h0};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp", {29'd0, rsp_valid, rsp_err, stall_lw}, 32'd0);
    check("rst_bus", {29'd0, data_bus_select, data_bus_mode}, 32'd0);
    check("rst_addr", data_bus_addr, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 19; i++)
      do_op(vecs[i].tag, vecs[i].st, vecs[i].w, vecs[i].sg, vecs[i].a,
            vecs[i].wd, vecs[i].exp_err, vecs[i].exp_rd);

    // Back-pressured load: response and bus must hold for 4 stalled cycles.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_store = 1'b0; req_width = 2'b10; req_signed = 1'b0;
    req_addr = 32'h3004;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      check("stall_lw", {31'd0, stall_lw}, 32'd1);
      check("stall_rdata", rsp_rdata, 32'hDEADBEEF);
      check("stall_bus", {data_bus_addr[29:0], data_bus_select, data_bus_mode[0]},
            {30'h3004, 1'b1, 1'b1});
      check("stall_busy", {30'd0, rsp_valid, req_ready}, 32'd2);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("stall_release", {30'd0, rsp_valid, stall_lw}, 32'd2);
    @(negedge clk);
    check("stall_idle", {30'd0, req_ready, rsp_valid}, 32'd2);
    $display("op stall_load: addr=0x00003004 rdata=0xDEADBEEF held 4 cycles");

    // Reset during the issue cycle of a store: the write still lands.
    req_valid = 1'b1; req_store = 1'b1; req_width = 2'b10; req_signed = 1'b0;
    req_addr = 32'h3010; req_wdata = 32'h12345678;
    @(negedge clk);
    req_valid = 1'b0;
    check("rstmid_issue", {29'd0, data_bus_select, data_bus_mode}, 32'd6);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_out", {28'd0, rsp_valid, stall_lw, data_bus_select, data_bus_mode[0]}, 32'd0);
    check("rstmid_mode", {30'd0, data_bus_mode}, 32'd0);
    check("rstmid_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    check("rstmid_norsp", {31'd0, rsp_valid}, 32'd0);
    $display("op reset_in_issue: store 0x12345678 @0x00003010 aborted after bus write");
    do_op("ld_w_3010", 1'b0, 2'b10, 1'b0, 32'h3010, 32'h0, 1'b0, 32'h12345678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
